// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
// Sequencer for a multi-cycle radix-2 shift-add multiplier serving RV32 MUL
// in the single-issue datapath. A request is accepted from decode only in
// IDLE. The PC is frozen while the loop runs, and a one-cycle register-file
// writeback is issued when the product is ready.
//
// Parameters
//   WIDTH      operand/result width; the result is the low WIDTH bits of a*b
//   EARLY_EXIT 1 = leave the loop once the remaining multiplier is zero
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   req_i      decoded instruction is MUL (qualified by decode)
//   flush_i    abort any in-flight multiply, no writeback
//   op_a_i     RS1 data (multiplicand)
//   op_b_i     RS2 data (multiplier)
//   rd_addr_i  destination register
//   PCWrite_o  0 = hold PC
//   busy_o     state is BUSY
//   result_o   product; holds its last value outside DONE
//   RegWrite_o writeback strobe (suppressed for x0)
//   rd_addr_o  latched destination register
module mul_seq_ctrl #(
  parameter int WIDTH      = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [4:0]       rd_addr_i,
  output logic             PCWrite_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             RegWrite_o,
  output logic [4:0]       rd_addr_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  stateT            r_state;
  stateT            w_nextState;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_rd;

  logic             w_accept;
  logic             w_step;
  logic             w_lastIter;
  logic             w_doneLive;
  logic [WIDTH-1:0] w_accNext;
  logic [WIDTH-1:0] w_mplierNext;

  // A request is taken only from IDLE, and a simultaneous flush always wins.
  // One loop iteration runs in every BUSY cycle that is not being flushed.
  // The DONE cycle is "live" (it drives the product and the writeback) unless
  // a flush arrives in that same cycle.
  assign w_accept   = (r_state == IDLE) && req_i && !flush_i;
  assign w_step     = (r_state == BUSY) && !flush_i;
  assign w_doneLive = (r_state == DONE) && !flush_i;

  // One shift-add iteration. The accumulator wraps mod 2^WIDTH, which keeps
  // the low half correct for two's-complement operands as well. The loop
  // ends either on the final bit position or, with early exit, when no set
  // multiplier bits remain after this iteration's shift.
  assign w_accNext    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplierNext = r_mplier >> 1;
  assign w_lastIter   = (r_count == LAST_COUNT) ||
                        ((EARLY_EXIT != 0) && (w_mplierNext == '0));

  // State register. A reset in any state drops straight back to IDLE, so an
  // in-flight multiply never reaches its writeback.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control outputs. The PC is released by default. It is held
  // in the acceptance cycle so the MUL stays in decode, and it is held for
  // every BUSY cycle. A flush releases the PC immediately and forces IDLE.
  // DONE always lasts one cycle and ignores req_i, because req_i is still the
  // same MUL that was just served.
  always_comb begin
    w_nextState = r_state;
    PCWrite_o   = 1'b1;
    busy_o      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = BUSY;
          PCWrite_o   = 1'b0;
        end
      end
      BUSY: begin
        busy_o = 1'b1;
        if (flush_i) begin
          w_nextState = IDLE;
        end else begin
          PCWrite_o = 1'b0;
          if (w_lastIter) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers. On acceptance the operands and destination are
  // captured, so later changes on the register-file ports cannot disturb the
  // loop. During BUSY the multiplicand walks left and the multiplier walks
  // right, one bit per cycle. A flush leaves everything untouched. The next
  // acceptance reinitialises these registers anyway.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_rd     <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= op_a_i;
      r_mplier <= op_b_i;
      r_count  <= '0;
      r_rd     <= rd_addr_i;
    end else if (w_step) begin
      r_acc    <= w_accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplierNext;
      r_count  <= r_count + CW'(1);
    end
  end

  // Result holding register. It only captures the accumulator when a DONE
  // cycle actually completes. A flushed DONE therefore leaves the previously
  // reported product on result_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_result <= '0;
    end else if (w_doneLive) begin
      r_result <= r_acc;
    end
  end

  // In a live DONE cycle the product is presented straight from the
  // accumulator. Outside DONE, result_o shows the last completed product.
  // Writes to x0 never raise the strobe.
  assign result_o   = w_doneLive ? r_acc : r_result;
  assign RegWrite_o = w_doneLive && (r_rd != 5'd0);
  assign rd_addr_o  = r_rd;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl
// Self-checking bench for mul_seq_ctrl. It uses two instances: dut0 has
// EARLY_EXIT=0 and dut1 has EARLY_EXIT=1. Each writeback that is expected is
// queued when its request is accepted. A monitor pops the queue on every
// RegWrite_o pulse and compares the result and the destination register.
module tb_mul_seq_ctrl;

  logic        clock;
  logic        reset;
  logic        req0, req1, flush0, flush1;
  logic [31:0] opA, opB;
  logic [4:0]  rdAddr;

  logic        pc0, busy0, wr0;
  logic        pc1, busy1, wr1;
  logic [31:0] res0, res1;
  logic [4:0]  rdo0, rdo1;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    bit          sel;
    logic [31:0] result;
    logic [4:0]  rd;
  } wbT;

  wbT sbQ[$];

  mul_seq_ctrl #(.WIDTH(32), .EARLY_EXIT(0)) dut0 (
    .clk_i(clock), .rst_i(reset), .req_i(req0), .flush_i(flush0),
    .op_a_i(opA), .op_b_i(opB), .rd_addr_i(rdAddr),
    .PCWrite_o(pc0), .busy_o(busy0), .result_o(res0),
    .RegWrite_o(wr0), .rd_addr_o(rdo0)
  );

  mul_seq_ctrl #(.WIDTH(32), .EARLY_EXIT(1)) dut1 (
    .clk_i(clock), .rst_i(reset), .req_i(req1), .flush_i(flush1),
    .op_a_i(opA), .op_b_i(opB), .rd_addr_i(rdAddr),
    .PCWrite_o(pc1), .busy_o(busy1), .result_o(res1),
    .RegWrite_o(wr1), .rd_addr_o(rdo1)
  );

  // Free-running clock with a 10-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every comparison in the bench goes through this task. It counts the
  // comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // These accessors select one of the two instances, so the same stimulus
  // task can drive either of them.
  function automatic logic pcOut(input bit s);
    return s ? pc1 : pc0;
  endfunction
  function automatic logic busyOut(input bit s);
    return s ? busy1 : busy0;
  endfunction
  function automatic logic wrOut(input bit s);
    return s ? wr1 : wr0;
  endfunction
  function automatic logic [31:0] resOut(input bit s);
    return s ? res1 : res0;
  endfunction
  function automatic logic [4:0] rdOut(input bit s);
    return s ? rdo1 : rdo0;
  endfunction

  task automatic setReq(input bit s, input logic v);
    if (s) req1 = v; else req0 = v;
  endtask
  task automatic setFlush(input bit s, input logic v);
    if (s) flush1 = v; else flush0 = v;
  endtask

  // This gives the number of BUSY cycles that each variant should spend.
  // Without early exit the count is always 32. With early exit it is the
  // position of the highest set bit plus one, and never less than one.
  function automatic int expectedBusy(input bit s, input logic [31:0] b);
    int hi;
    hi = 0;
    if (!s) return 32;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) hi = i + 1;
    end
    return (hi == 0) ? 1 : hi;
  endfunction

  // Writeback monitor. Every strobe must match the oldest queued
  // expectation. A strobe that arrives with nothing queued is an error.
  initial begin
    wbT exp;
    forever begin
      @(negedge clock);
      #3;
      for (int s = 0; s < 2; s++) begin
        if (wrOut(s[0])) begin
          if (sbQ.size() == 0) begin
            checkOutput("wbUnexpected", 32'd1, 32'd0);
          end else begin
            exp = sbQ.pop_front();
            checkOutput("wbInstance", 32'(s), 32'(exp.sel));
            checkOutput("wbResult", resOut(s[0]), exp.result);
            checkOutput("wbRd", 32'(rdOut(s[0])), 32'(exp.rd));
          end
        end
      end
    end
  end

  // This task issues one MUL to the selected instance. It counts the BUSY
  // cycles and the cycles with the PC held, and it checks the DONE cycle.
  // Operands are scrambled after acceptance to show that they are latched.
  // A nonzero flushAt pulses flush_i in that BUSY cycle. holdReq keeps req_i
  // asserted through DONE.
  task automatic applyStimulus(input bit s, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input bit holdReq, input int flushAt);
    int          busyCycles, pcLow, expBusy, guard;
    logic [31:0] expProd, prevRes;
    bit          flushed;
    wbT          entry;
    expProd    = a * b;
    expBusy    = expectedBusy(s, b);
    busyCycles = 0;
    pcLow      = 1;
    guard      = 0;
    flushed    = 0;
    @(negedge clock);
    #1;
    prevRes = resOut(s);
    opA     = a;
    opB     = b;
    rdAddr  = rd;
    setReq(s, 1'b1);
    #1;
    checkOutput("pcHoldAccept", 32'(pcOut(s)), 32'd0);
    if (rd != 5'd0 && flushAt == 0) begin
      entry.sel    = s;
      entry.result = expProd;
      entry.rd     = rd;
      sbQ.push_back(entry);
    end
    @(negedge clock);
    #1;
    if (!holdReq) setReq(s, 1'b0);
    opA = ~a;
    opB = ~b;
    #1;
    while (busyOut(s) && guard < 100) begin
      busyCycles++;
      guard++;
      if (busyCycles == flushAt) begin
        setFlush(s, 1'b1);
        #1;
        checkOutput("pcFlushCycle", 32'(pcOut(s)), 32'd1);
        checkOutput("wrFlushCycle", 32'(wrOut(s)), 32'd0);
        flushed = 1;
      end else if (!pcOut(s)) begin
        pcLow++;
      end
      @(negedge clock);
      #1;
      setFlush(s, 1'b0);
      #1;
    end
    checkOutput("busyTimeout", 32'(guard < 100), 32'd1);
    if (flushed) begin
      checkOutput("flushIdle", 32'(busyOut(s)), 32'd0);
      checkOutput("flushPc", 32'(pcOut(s)), 32'd1);
      checkOutput("flushNoWrite", 32'(wrOut(s)), 32'd0);
      checkOutput("flushResultHeld", resOut(s), prevRes);
    end else begin
      checkOutput("busyCycles", 32'(busyCycles), 32'(expBusy));
      checkOutput("pcLowCycles", 32'(pcLow), 32'(expBusy + 1));
      checkOutput("doneResult", resOut(s), expProd);
      checkOutput("doneRegWrite", 32'(wrOut(s)), 32'(rd != 5'd0));
      checkOutput("doneRd", 32'(rdOut(s)), 32'(rd));
      checkOutput("donePc", 32'(pcOut(s)), 32'd1);
      checkOutput("doneBusy", 32'(busyOut(s)), 32'd0);
      setReq(s, 1'b0);
      @(negedge clock);
      #2;
      checkOutput("idleBusy", 32'(busyOut(s)), 32'd0);
      checkOutput("idleNoWrite", 32'(wrOut(s)), 32'd0);
      checkOutput("resultHeld", resOut(s), expProd);
    end
  endtask

  // This checks that the selected instance shows its reset values.
  task automatic checkResetState(input bit s);
    checkOutput("rstBusy", 32'(busyOut(s)), 32'd0);
    checkOutput("rstPc", 32'(pcOut(s)), 32'd1);
    checkOutput("rstResult", resOut(s), 32'd0);
    checkOutput("rstRd", 32'(rdOut(s)), 32'd0);
    checkOutput("rstRegWrite", 32'(wrOut(s)), 32'd0);
  endtask

  // Main sequence.
  initial begin
    reset  = 1'b1;
    req0   = 1'b0;
    req1   = 1'b0;
    flush0 = 1'b0;
    flush1 = 1'b0;
    opA    = '0;
    opB    = '0;
    rdAddr = '0;
    repeat (2) @(negedge clock);
    #1;
    checkResetState(1'b0);
    checkResetState(1'b1);
    reset = 1'b0;

    applyStimulus(1'b0, 32'd7, 32'd6, 5'd5, 1'b0, 0);
    applyStimulus(1'b1, 32'h0000_1234, 32'd3, 5'd7, 1'b0, 0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0, 0);
    applyStimulus(1'b1, 32'h8000_0000, 32'd2, 5'd10, 1'b0, 0);
    applyStimulus(1'b1, 32'd5, 32'd5, 5'd0, 1'b0, 0);
    applyStimulus(1'b1, 32'h77, 32'd0, 5'd3, 1'b0, 0);
    applyStimulus(1'b0, 32'd100, 32'd200, 5'd11, 1'b0, 10);
    applyStimulus(1'b0, 32'd3, 32'd4, 5'd12, 1'b0, 0);

    // When flush and request arrive together in IDLE, the flush wins.
    @(negedge clock);
    #1;
    req1   = 1'b1;
    flush1 = 1'b1;
    #1;
    checkOutput("flushReqPc", 32'(pc1), 32'd1);
    @(negedge clock);
    #1;
    req1   = 1'b0;
    flush1 = 1'b0;
    #1;
    checkOutput("flushReqIdle", 32'(busy1), 32'd0);

    // With req_i held high through DONE, only one writeback may occur.
    applyStimulus(1'b1, 32'd13, 32'd11, 5'd4, 1'b1, 0);

    // An asynchronous reset in the middle of BUSY aborts the multiply at once.
    @(negedge clock);
    #1;
    opA    = 32'd9;
    opB    = 32'd9;
    rdAddr = 5'd6;
    req0   = 1'b1;
    @(negedge clock);
    #1;
    req0 = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    checkOutput("preResetBusy", 32'(busy0), 32'd1);
    reset = 1'b1;
    #1;
    checkResetState(1'b0);
    @(negedge clock);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("postResetIdle", 32'(busy0), 32'd0);
    checkOutput("postResetNoWrite", 32'(wr0), 32'd0);

    repeat (2) @(negedge clock);
    checkOutput("queueDrained", 32'(sbQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencer for a multi-cycle iterative multiplier that serves decoded MUL instructions (ALU control code 3'b011) in the single-issue RISC-V datapath.
- Accepts a MUL request from decode and runs a radix-2 shift-add loop over operands latched from the register file.
- Freezes the PC through PCWrite_o while it runs, then issues a one-cycle writeback to the register file.
- Sits between Control/ALU_Control, Registers, and PC. It owns the PC stall for MUL only.

Parameters:
- WIDTH, 32, operand and result width in bits. The result is the low WIDTH bits of the product, per RV32 MUL.
- EARLY_EXIT, 1, when 1 the loop terminates as soon as the remaining multiplier is zero.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- req_i  input  1  decoded instruction is MUL (qualified by decode).
- flush_i  input  1  abort any in-flight multiply; no writeback.
- op_a_i  input  WIDTH  RS1 data (multiplicand).
- op_b_i  input  WIDTH  RS2 data (multiplier).
- rd_addr_i  input  5  destination register.
- PCWrite_o  output  1  0 = hold PC; drives PC.PCWrite_i.
- busy_o  output  1  state is BUSY.
- result_o  output  WIDTH  product; holds its last value outside DONE.
- RegWrite_o  output  1  writeback strobe to Registers.
- rd_addr_o  output  5  latched destination register.

Behaviour:
- Reset values (asynchronous on rst_i high):
  - state = IDLE
  - accumulator, multiplicand, multiplier, count, result_o, rd_addr_o = 0
  - RegWrite_o = 0, busy_o = 0, PCWrite_o = 1
- Reset mid-operation aborts immediately with no writeback.
- States: IDLE, BUSY, DONE.
- IDLE:
  - With req_i=1 and flush_i=0: latch op_a_i, op_b_i, rd_addr_i; clear accumulator and count; next state BUSY.
  - PCWrite_o is combinationally 0 in this cycle (req_i & ~flush_i), so the MUL stays in decode.
  - Otherwise remain in IDLE with PCWrite_o=1.
- BUSY, one iteration per cycle:
  - If multiplier[0]=1, accumulator += multiplicand, mod 2^WIDTH.
  - Multiplicand shifts left 1 with zero fill; multiplier shifts right 1 (logical); count += 1.
  - PCWrite_o=0 and busy_o=1.
  - Go to DONE after the iteration where count reaches WIDTH-1.
  - If EARLY_EXIT=1, also go to DONE after any iteration whose shifted multiplier is 0.
  - At least one BUSY cycle always occurs, including when op_b_i=0.
- DONE, exactly one cycle:
  - result_o = accumulator.
  - RegWrite_o = 1 unless rd_addr_o = 0 (writes to x0 are suppressed).
  - PCWrite_o = 1 and busy_o = 0; next state IDLE.
  - req_i is ignored in DONE, because it is still the same MUL instruction. A fresh request is accepted only in IDLE.
- Latency:
  - EARLY_EXIT=0: request accepted in cycle 0, BUSY in cycles 1..WIDTH, DONE in cycle WIDTH+1. The PC is held WIDTH+1 cycles.
  - EARLY_EXIT=1: the number of BUSY cycles equals the index of the highest set bit of op_b + 1, minimum 1.
- flush_i:
  - Any state returns to IDLE next cycle with no RegWrite_o pulse; result_o keeps its previous value.
  - PCWrite_o=1 in the flush cycle.
  - Flush in DONE suppresses that cycle's RegWrite_o combinationally.
  - flush_i together with req_i in IDLE: flush wins, request not accepted.
- Operands are latched at acceptance. Changes on op_a_i/op_b_i during BUSY have no effect.
- Arithmetic is unsigned shift-add. The low WIDTH bits are correct for signed operands as well (two's complement); overflow bits are discarded.

Test Plan:
- Reset then 7 × 6 (rd=5, EARLY_EXIT=0) -> PCWrite_o low for 33 cycles; DONE at cycle 33 with result_o=42, RegWrite_o=1 for 1 cycle, rd_addr_o=5.
- EARLY_EXIT=1, 0x0000_1234 × 3 -> exactly 2 BUSY cycles; result_o=0x0000_369C in DONE.
- 0xFFFF_FFFF × 0xFFFF_FFFF (i.e. -1 × -1) -> result_o=0x0000_0001; 0x8000_0000 × 2 -> 0x0000_0000 (overflow dropped).
- rd=0 with 5 × 5 -> result_o=25, RegWrite_o stays 0, PCWrite_o releases normally.
- flush_i pulsed in 10th BUSY cycle -> IDLE next cycle, no RegWrite_o, PCWrite_o=1; a new req_i next cycle completes correctly (e.g. 3 × 4 = 12).
- rst_i asserted asynchronously mid-BUSY -> outputs go to reset values before the next edge; req_i held high through DONE produces only one writeback per acceptance.
